// File: rtl/conversor_bases_seq_if.sv
// Handshake and result bundle for conversor_bases_seq.
// The master drives requests; the slave (the converter) returns status, digits and segments.
interface conversor_bases_seq_if #(
    parameter int WIDTH = 8,
    parameter int NDIG  = 4
);
    logic                  start;
    logic [WIDTH-1:0]      valor_binario;
    logic [1:0]            base_selecionada;
    logic                  busy;
    logic                  done;
    logic                  overflow;
    logic [4*NDIG-1:0]     digitos;
    logic [7*NDIG-1:0]     SEG;

    modport master (
        output start, valor_binario, base_selecionada,
        input  busy, done, overflow, digitos, SEG
    );

    modport slave (
        input  start, valor_binario, base_selecionada,
        output busy, done, overflow, digitos, SEG
    );
endinterface

// File: rtl/conversor_bases_seq.sv
// Sequential base converter (decimal/hex/octal/binary) with 7-segment decode, one operand bit per cycle.
// Optional build macro ZERO_BLANK_EN blanks leading zero displays (digit 0 always shown).
module conversor_bases_seq #(
    parameter int WIDTH = 8,
    parameter int NDIG  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    conversor_bases_seq_if.slave  cb_if
);
    localparam int CW = 6;

    typedef enum logic [0:0] {IDLE = 1'b0, CONV = 1'b1} state_t;

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    opnd_q, opnd_d;
    logic [1:0]          base_q, base_d;
    logic [4*NDIG-1:0]   work_q, work_d;
    logic                ovf_w_q, ovf_w_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                overflow_q, overflow_d;
    logic [4*NDIG-1:0]   digitos_q, digitos_d;

    logic [4*NDIG-1:0]   adj_s;
    logic [4*NDIG-1:0]   step_s;
    logic [NDIG-1:0]     cin_s;
    logic                carry_s;
    logic [7*NDIG-1:0]   seg_s;
    int                  k_s;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            4'hF:    s = 7'b0001110;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // One conversion step: double-dabble for decimal, k-bit-per-nibble shift for radix 2^k
    always_comb begin
        adj_s   = work_q;
        step_s  = '0;
        cin_s   = '0;
        carry_s = 1'b0;
        case (base_q)
            2'b01:   k_s = 4;
            2'b10:   k_s = 3;
            2'b11:   k_s = 1;
            default: k_s = 4;
        endcase
        if (base_q == 2'b00) begin
            for (int i = 0; i < NDIG; i++) begin
                if (work_q[4*i +: 4] >= 4'd5) begin
                    adj_s[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
                end else begin
                    adj_s[4*i +: 4] = work_q[4*i +: 4];
                end
            end
            step_s  = {adj_s[4*NDIG-2:0], opnd_q[WIDTH-1]};
            carry_s = adj_s[4*NDIG-1];
        end else begin
            cin_s[0] = opnd_q[WIDTH-1];
            for (int i = 1; i < NDIG; i++) begin
                cin_s[i] = work_q[4*(i-1) + k_s - 1];
            end
            for (int i = 0; i < NDIG; i++) begin
                for (int j = 0; j < 4; j++) begin
                    if (j == 0) begin
                        step_s[4*i] = cin_s[i];
                    end else if (j < k_s) begin
                        step_s[4*i + j] = work_q[4*i + j - 1];
                    end else begin
                        step_s[4*i + j] = 1'b0;
                    end
                end
            end
            carry_s = work_q[4*(NDIG-1) + k_s - 1];
        end
    end

    // Next-state and output-register logic for the IDLE/CONV controller
    always_comb begin
        state_d    = state_q;
        opnd_d     = opnd_q;
        base_d     = base_q;
        work_d     = work_q;
        ovf_w_d    = ovf_w_q;
        cnt_d      = cnt_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        overflow_d = overflow_q;
        digitos_d  = digitos_q;
        case (state_q)
            IDLE: begin
                if (cb_if.start) begin
                    opnd_d  = cb_if.valor_binario;
                    base_d  = cb_if.base_selecionada;
                    work_d  = '0;
                    ovf_w_d = 1'b0;
                    cnt_d   = CW'(WIDTH);
                    busy_d  = 1'b1;
                    state_d = CONV;
                end else begin
                    busy_d  = 1'b0;
                end
            end
            CONV: begin
                opnd_d  = opnd_q << 1;
                work_d  = step_s;
                ovf_w_d = ovf_w_q | carry_s;
                cnt_d   = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    digitos_d  = step_s;
                    overflow_d = ovf_w_q | carry_s;
                    done_d     = 1'b1;
                    busy_d     = 1'b0;
                    state_d    = IDLE;
                end else begin
                    busy_d     = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and result registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            opnd_q     <= '0;
            base_q     <= 2'b00;
            work_q     <= '0;
            ovf_w_q    <= 1'b0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            digitos_q  <= '0;
        end else begin
            state_q    <= state_d;
            opnd_q     <= opnd_d;
            base_q     <= base_d;
            work_q     <= work_d;
            ovf_w_q    <= ovf_w_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
            digitos_q  <= digitos_d;
        end
    end

`ifdef ZERO_BLANK_EN
    logic seen_s;

    // Display decode, blanking every digit above the most significant nonzero one
    always_comb begin
        seg_s  = '1;
        seen_s = 1'b0;
        for (int i = NDIG - 1; i >= 0; i--) begin
            if (digitos_q[4*i +: 4] != 4'd0) begin
                seen_s = 1'b1;
            end else begin
                seen_s = seen_s;
            end
            if (seen_s || (i == 0)) begin
                seg_s[7*i +: 7] = seg7(digitos_q[4*i +: 4]);
            end else begin
                seg_s[7*i +: 7] = 7'b1111111;
            end
        end
    end
`else
    // Display decode, every digit shown
    always_comb begin
        seg_s = '1;
        for (int i = 0; i < NDIG; i++) begin
            seg_s[7*i +: 7] = seg7(digitos_q[4*i +: 4]);
        end
    end
`endif

    assign cb_if.busy     = busy_q;
    assign cb_if.done     = done_q;
    assign cb_if.overflow = overflow_q;
    assign cb_if.digitos  = digitos_q;
    assign cb_if.SEG      = seg_s;
endmodule

// File: tb/tb_conversor_bases_seq.sv
// Directed bench for conversor_bases_seq: three instances (8b/4 digits, 12b/4 digits, 8b/2 digits).
module tb_conversor_bases_seq;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    int   lat;
    int   ndone;

`ifdef ZERO_BLANK_EN
    localparam logic [6:0] BLK = 7'b1111111;
`else
    localparam logic [6:0] BLK = 7'b1000000;
`endif

    conversor_bases_seq_if #(.WIDTH(8),  .NDIG(4)) if8  ();
    conversor_bases_seq_if #(.WIDTH(12), .NDIG(4)) if12 ();
    conversor_bases_seq_if #(.WIDTH(8),  .NDIG(2)) if2  ();

    conversor_bases_seq #(.WIDTH(8),  .NDIG(4)) u8  (.clk(clk), .rst_n(rst_n), .cb_if(if8));
    conversor_bases_seq #(.WIDTH(12), .NDIG(4)) u12 (.clk(clk), .rst_n(rst_n), .cb_if(if12));
    conversor_bases_seq #(.WIDTH(8),  .NDIG(2)) u2  (.clk(clk), .rst_n(rst_n), .cb_if(if2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Called 1 time unit after a rising edge; returns cycles from the start edge to done
    task automatic conv8(input logic [1:0] b, input logic [7:0] v, output int l);
        if8.base_selecionada = b;
        if8.valor_binario    = v;
        if8.start            = 1'b1;
        @(posedge clk); #1;
        if8.start = 1'b0;
        l = 0;
        while (if8.done !== 1'b1 && l < 100) begin
            @(posedge clk); #1;
            l++;
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        if8.start = 1'b0;  if8.valor_binario = 8'd0;   if8.base_selecionada = 2'b00;
        if12.start = 1'b0; if12.valor_binario = 12'd0; if12.base_selecionada = 2'b00;
        if2.start = 1'b0;  if2.valor_binario = 8'd0;   if2.base_selecionada = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(if8.busy), 32'd0);
        check("rst_done", 32'(if8.done), 32'd0);
        check("rst_ovf", 32'(if8.overflow), 32'd0);
        check("rst_dig", 32'(if8.digitos), 32'h0000);
        rst_n = 1'b1;
        @(posedge clk); #1;

        conv8(2'b00, 8'd255, lat);
        check("dec255_lat", 32'(lat), 32'd8);
        check("dec255_dig", 32'(if8.digitos), 32'h0255);
        check("dec255_ovf", 32'(if8.overflow), 32'd0);
        check("dec255_busy", 32'(if8.busy), 32'd0);
        @(posedge clk); #1;
        check("done_pulse", 32'(if8.done), 32'd0);

        conv8(2'b01, 8'hA7, lat);
        check("hexA7_dig", 32'(if8.digitos), 32'h00A7);
        check("hexA7_ovf", 32'(if8.overflow), 32'd0);
        check("hexA7_seg0", 32'(if8.SEG[6:0]), 32'(7'b1111000));
        check("hexA7_seg1", 32'(if8.SEG[13:7]), 32'(7'b0001000));

        conv8(2'b10, 8'd255, lat);
        check("oct255_dig", 32'(if8.digitos), 32'h0377);
        check("oct255_ovf", 32'(if8.overflow), 32'd0);

        conv8(2'b11, 8'b1011_0110, lat);
        check("binB6_lat", 32'(lat), 32'd8);
        check("binB6_dig", 32'(if8.digitos), 32'h0110);
        check("binB6_ovf", 32'(if8.overflow), 32'd1);

        // Reset at step 4 of a conversion
        if8.base_selecionada = 2'b00;
        if8.valor_binario    = 8'd200;
        if8.start            = 1'b1;
        @(posedge clk); #1;
        if8.start = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrst_busy", 32'(if8.busy), 32'd0);
        check("midrst_done", 32'(if8.done), 32'd0);
        check("midrst_dig", 32'(if8.digitos), 32'h0000);
        check("midrst_ovf", 32'(if8.overflow), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        conv8(2'b00, 8'd42, lat);
        check("dec42_lat", 32'(lat), 32'd8);
        check("dec42_dig", 32'(if8.digitos), 32'h0042);

        // Start pulsed mid-conversion is dropped; outputs hold the old result until done
        @(posedge clk); #1;
        if8.base_selecionada = 2'b00;
        if8.valor_binario    = 8'd18;
        if8.start            = 1'b1;
        @(posedge clk); #1;
        if8.start = 1'b0;
        check("conv_busy", 32'(if8.busy), 32'd1);
        check("hold_dig", 32'(if8.digitos), 32'h0042);
        @(posedge clk); #1;
        @(posedge clk); #1;
        if8.start            = 1'b1;
        if8.valor_binario    = 8'd99;
        if8.base_selecionada = 2'b01;
        @(posedge clk); #1;
        if8.start = 1'b0;
        ndone = 0;
        for (int c = 0; c < 25; c++) begin
            if (if8.done === 1'b1) ndone++;
            @(posedge clk); #1;
        end
        check("ignore_ndone", 32'(ndone), 32'd1);
        check("ignore_dig", 32'(if8.digitos), 32'h0018);

        // Back-to-back: second start issued in the done cycle
        conv8(2'b00, 8'd5, lat);
        check("b2b_first", 32'(if8.digitos), 32'h0005);
        conv8(2'b00, 8'd9, lat);
        check("b2b_gap", 32'(lat + 1), 32'd9);
        check("b2b_dig", 32'(if8.digitos), 32'h0009);

        conv8(2'b00, 8'd7, lat);
        check("seg7_dig", 32'(if8.digitos), 32'h0007);
        check("seg7_hex0", 32'(if8.SEG[6:0]), 32'(7'b1111000));
        check("seg7_hex1", 32'(if8.SEG[13:7]), 32'(BLK));
        check("seg7_hex3", 32'(if8.SEG[27:21]), 32'(BLK));
        conv8(2'b00, 8'd0, lat);
        check("zero_hex0", 32'(if8.SEG[6:0]), 32'(7'b1000000));
        check("zero_hex2", 32'(if8.SEG[20:14]), 32'(BLK));

        // WIDTH=12 instance
        if12.base_selecionada = 2'b00;
        if12.valor_binario    = 12'd4095;
        if12.start            = 1'b1;
        @(posedge clk); #1;
        if12.start = 1'b0;
        lat = 0;
        while (if12.done !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check("w12_lat", 32'(lat), 32'd12);
        check("w12_dig", 32'(if12.digitos), 32'h4095);
        check("w12_ovf", 32'(if12.overflow), 32'd0);

        // NDIG=2 instance overflows on 255
        if2.base_selecionada = 2'b00;
        if2.valor_binario    = 8'd255;
        if2.start            = 1'b1;
        @(posedge clk); #1;
        if2.start = 1'b0;
        lat = 0;
        while (if2.done !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check("n2_lat", 32'(lat), 32'd8);
        check("n2_dig", 32'(if2.digitos), 32'h55);
        check("n2_ovf", 32'(if2.overflow), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
